label_resolver: RTL
===================

// Module: label_resolver
// PURPOSE
//   Resolves a provisional component label to its root via the parent-pointer equivalence RAM.
//   Sits upstream of the label stack and drives its push/pop port.
//   Walks the chain to the root, pushing every non-root label it visits.
//   Then pops each pushed label and rewrites its parent to the root (path compression).
//   Feeds the root label to the downstream blob-statistics stage.
// PARAMETERS
//   LABEL_W   11   label / RAM address width; label 0 = background, never requested
//   STK_LOG2  7    log2 of the stack depth; the stack holds 2**STK_LOG2 entries
//   MAX_HOPS  255  hop limit per request; exceeding it flags a chain cycle
// PORTS
//   clk        in   1        clock
//   reset      in   1        synchronous, active-high
//   req_valid  in   1        request valid
//   req_label  in   LABEL_W  label to resolve
//   req_ready  out  1        high only in IDLE
//   res_valid  out  1        result valid; held until accepted
//   res_ready  in   1        downstream accept
//   res_root   out  LABEL_W  root label
//   res_err    out  1        hop limit hit; res_root = last label reached
//   ram_rd_en  out  1        RAM read enable; read data valid 1 cycle later
//   ram_addr   out  LABEL_W  RAM read/write address
//   ram_rd_data in  LABEL_W  parent of the label at ram_addr
//   ram_wr_en  out  1        RAM write enable (parent := ram_wr_data)
//   ram_wr_data out LABEL_W  root written back
//   stk_push   out  1        stack push of stk_d
//   stk_pop    out  1        stack pop; stk_q valid the following cycle
//   stk_d      out  LABEL_W  label pushed
//   stk_q      in   LABEL_W  label popped
//   stk_full   in   1        stack full
//   ovf        out  1        sticky: a push was dropped because the stack was full
// BEHAVIOUR
//   Reset outputs: all outputs 0 except req_ready=1; ovf cleared; state IDLE; push and hop counts 0.
//   FSM states: IDLE, READ, CHECK, POP, WRITE, DONE.
//   IDLE:  on req_valid && req_ready -> cur <= req_label; go to READ.
//   READ:  ram_rd_en=1, ram_addr=cur; go to CHECK.
//   CHECK (parent P = ram_rd_data):
//     P==cur -> root <= cur; go to POP if pcnt>0, else DONE.
//     P!=cur && hops==MAX_HOPS -> res_err <= 1; root <= cur; go to POP/DONE as above.
//     otherwise:
//       push cur if !stk_full and increment pcnt; else set ovf and skip the push.
//       cur <= P; hops++; go to READ.
//   Each hop costs 2 cycles. The push/pop count pcnt is tracked locally; stk_empty is not used.
//   POP:   stk_pop=1; pcnt--; go to WRITE.
//   WRITE: ram_wr_en=1, ram_addr=stk_q, ram_wr_data=root; go to POP if pcnt>0, else DONE.
//   DONE:  res_valid=1 with res_root and res_err stable; on res_ready -> IDLE, clear hops and res_err.
//   Latency (root input, no hops): res_valid 3 cycles after accept. Chain of k hops: 3 + 4k cycles.
//   Never asserts push and pop in the same cycle; never asserts rd_en and wr_en together.
//   Labels pushed by one request are all popped before res_valid, so the stack is balanced per request.
//   Reset mid-walk: immediately IDLE, pcnt=0; the parent must also reset the stack.
//   The RAM may hold partial compression after such a reset; this is harmless.
// CONFIGURATION
//   LABEL_RESOLVE_COMPRESS_EN defined:
//     full behaviour above (push/pop/write-back).
//   LABEL_RESOLVE_COMPRESS_EN undefined:
//     CHECK never pushes and POP/WRITE are unreachable.
//     stk_push, stk_pop, ram_wr_en and ovf are tied 0.
//     Latency is 3 + 2k; root results are identical.
// STRUCTURE
//   detect_pkg: label_t (logic [LABEL_W-1:0]), resolver state enum, LABEL_BG=0.
//   No sub-module: a single FSM plus counters. The stack and RAM are instantiated by the parent.
// TESTING
//   1. RAM[5]=5; request 5 -> res_root=5, res_err=0, no push, res_valid 3 cycles after accept.
//   2. RAM 9->7->4->4; request 9 -> root 4 after 11 cycles; 2 pushes then 2 pops.
//      Afterwards RAM[9]=4 and RAM[7]=4.
//   3. Repeat scenario 2 -> chain is now 9->4: root 4, 1 hop, latency 7.
//   4. Chain longer than the stack (stk_full forced) -> correct root, ovf=1, only pushed labels rewritten.
//   5. RAM 3->6->3 cycle, MAX_HOPS=4 -> res_err=1, terminates.
//      res_valid held until res_ready rises 5 cycles later.
//   6. reset asserted during WRITE -> next cycle req_ready=1, all strobes 0; a following request resolves correctly.

Source files
------------

// File: rtl/label_resolver_pkg.sv
// Shared types for the label resolver: label type, background label, FSM states.
package label_resolver_pkg;

    localparam int unsigned DEF_LABEL_W = 11;

    typedef logic [DEF_LABEL_W-1:0] label_t;

    localparam label_t LABEL_BG = '0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_CHECK,
        S_POP,
        S_WRITE,
        S_DONE
    } state_t;

endpackage

// File: rtl/label_resolver_if.sv
// Request/result handshake between the label producer, the resolver and blob statistics.
interface label_resolver_if
    import label_resolver_pkg::*;
#(
    parameter int unsigned LABEL_W = DEF_LABEL_W
);
    logic               req_valid;
    logic               req_ready;
    logic [LABEL_W-1:0] req_label;
    logic               res_valid;
    logic               res_ready;
    logic [LABEL_W-1:0] res_root;
    logic               res_err;

    modport master (
        output req_valid, req_label, res_ready,
        input  req_ready, res_valid, res_root, res_err
    );

    modport slave (
        input  req_valid, req_label, res_ready,
        output req_ready, res_valid, res_root, res_err
    );
endinterface

// File: rtl/label_resolver.sv
// Walks the parent-pointer RAM to a label's root; with LABEL_RESOLVE_COMPRESS_EN defined it
// also pushes visited labels and rewrites them to the root (path compression).
module label_resolver
    import label_resolver_pkg::*;
#(
    parameter int unsigned LABEL_W  = DEF_LABEL_W,
    parameter int unsigned STK_LOG2 = 7,
    parameter int unsigned MAX_HOPS = 255
) (
    input  logic               clk,
    input  logic               reset,
    label_resolver_if.slave    bus,
    output logic               ram_rd_en,
    output logic [LABEL_W-1:0] ram_addr,
    input  logic [LABEL_W-1:0] ram_rd_data,
    output logic               ram_wr_en,
    output logic [LABEL_W-1:0] ram_wr_data,
    output logic               stk_push,
    output logic               stk_pop,
    output logic [LABEL_W-1:0] stk_d,
    input  logic [LABEL_W-1:0] stk_q,
    input  logic               stk_full,
    output logic               ovf
);
    localparam int unsigned HOP_W = $clog2(MAX_HOPS + 1);

    state_t             state, state_nx;
    logic [LABEL_W-1:0] cur;
    logic [LABEL_W-1:0] root;
    logic               err_q;
    logic [HOP_W-1:0]   hops;
    logic               at_root;
    logic               hop_lim;

    assign at_root = (ram_rd_data == cur);
    assign hop_lim = (hops == HOP_W'(MAX_HOPS));

`ifdef LABEL_RESOLVE_COMPRESS_EN
    localparam int unsigned PC_W = STK_LOG2 + 1;
    logic [PC_W-1:0] pcnt;
    logic            ovf_q;
    logic            walk_end_pop;

    // pcnt mirrors the stack occupancy for this request, so the shared stack's empty flag is not needed
    assign walk_end_pop = (pcnt != '0);
    assign ovf          = ovf_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            pcnt  <= '0;
            ovf_q <= 1'b0;
        end else begin
            if (state == S_CHECK && !at_root && !hop_lim) begin
                if (stk_full) ovf_q <= 1'b1;
                else          pcnt  <= pcnt + 1'b1;
            end else if (state == S_POP) begin
                pcnt <= pcnt - 1'b1;
            end
        end
    end
`else
    logic walk_end_pop;
    logic unused_stk;

    assign walk_end_pop = 1'b0;
    assign ovf          = 1'b0;
    assign unused_stk   = ^{stk_q, stk_full, 1'(STK_LOG2)};
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            cur   <= '0;
            root  <= '0;
            err_q <= 1'b0;
            hops  <= '0;
        end else begin
            state <= state_nx;
            case (state)
                S_IDLE: if (bus.req_valid) cur <= bus.req_label;
                S_CHECK: begin
                    if (at_root || hop_lim) begin
                        root <= cur;
                        if (!at_root) err_q <= 1'b1;
                    end else begin
                        cur  <= ram_rd_data;
                        hops <= hops + 1'b1;
                    end
                end
                S_DONE: begin
                    if (bus.res_ready) begin
                        hops  <= '0;
                        err_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx    = state;
        ram_rd_en   = 1'b0;
        ram_wr_en   = 1'b0;
        ram_addr    = '0;
        ram_wr_data = '0;
        stk_push    = 1'b0;
        stk_pop     = 1'b0;
        stk_d       = '0;
        case (state)
            S_IDLE: if (bus.req_valid) state_nx = S_READ;
            S_READ: begin
                ram_rd_en = 1'b1;
                ram_addr  = cur;
                state_nx  = S_CHECK;
            end
            S_CHECK: begin
                if (at_root || hop_lim) begin
                    state_nx = walk_end_pop ? S_POP : S_DONE;
                end else begin
`ifdef LABEL_RESOLVE_COMPRESS_EN
                    if (!stk_full) begin
                        stk_push = 1'b1;
                        stk_d    = cur;
                    end
`endif
                    state_nx = S_READ;
                end
            end
`ifdef LABEL_RESOLVE_COMPRESS_EN
            S_POP: begin
                stk_pop  = 1'b1;
                state_nx = S_WRITE;
            end
            S_WRITE: begin
                ram_wr_en   = 1'b1;
                ram_addr    = stk_q;
                ram_wr_data = root;
                state_nx    = walk_end_pop ? S_POP : S_DONE;
            end
`endif
            S_DONE: if (bus.res_ready) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    assign bus.req_ready = (state == S_IDLE);
    assign bus.res_valid = (state == S_DONE);
    assign bus.res_root  = root;
    assign bus.res_err   = err_q;

endmodule
